lfsr_random_arbiter: RTL and testbench

Shares one 7-bit XNOR LFSR among N requesters that each need a bounded random value, e.g. a random victim way or slot index in the cache replacement logic. It arbitrates requests round-robin and advances the LFSR only while serving a grant. It returns a uniformly drawn value in [0, lim) by rejection sampling. It also supports run-time reseeding.

---
 rtl/lfsr_random_arbiter_pkg.sv | 24 ++
 rtl/lfsr_random_arbiter_if.sv | 22 ++
 rtl/lfsr_random_arbiter_lfsr.sv | 24 ++
 rtl/lfsr_random_arbiter.sv | 118 +++++++++++
 tb/tb_lfsr_random_arbiter.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_random_arbiter_pkg.sv
// Shared constants, FSM encoding and the rejection-sampling mask helper
// for the LFSR random arbiter.
package lfsr_random_arbiter_pkg;

  localparam int LFSR_W = 7;
  localparam logic [LFSR_W-1:0] LFSR_RESET  = 7'h04;
  localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 7'h7F;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

  // Smallest all-ones value covering bound-1, i.e. next power of two minus one.
  function automatic logic [LFSR_W-1:0] lfsr_mask(input logic [LFSR_W-1:0] bound);
    logic [LFSR_W-1:0] v;
    v = bound - 1'b1;
    v = v | (v >> 1);
    v = v | (v >> 2);
    v = v | (v >> 4);
    return v;
  endfunction

endpackage

// File: rtl/lfsr_random_arbiter_if.sv
// Request/response bundle between the requesters and the random arbiter.
interface lfsr_random_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [7*N_REQ-1:0] lim;
  logic               seed_ld;
  logic [6:0]         seed;
  logic [N_REQ-1:0]   ack;
  logic [6:0]         data;
  logic               busy;

  modport master (
    output req, lim, seed_ld, seed,
    input  ack, data, busy
  );

  modport slave (
    input  req, lim, seed_ld, seed,
    output ack, data, busy
  );
endinterface

// File: rtl/lfsr_random_arbiter_lfsr.sv
// 7-bit XNOR LFSR with reset seed and lockup-safe parallel load.
module lfsr_core_7b
  import lfsr_random_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  output logic [LFSR_W-1:0] out
);

  // All-ones would freeze an XNOR LFSR, so a lockup seed falls back to the reset seed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out <= LFSR_RESET;
    end else if (load) begin
      out <= (load_val == LFSR_LOCKUP) ? LFSR_RESET : load_val;
    end else if (enable) begin
      out <= {~(out[0] ^ out[1]), out[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_random_arbiter.sv
// Round-robin arbiter handing out bounded random values from one shared LFSR
// via rejection sampling.
module lfsr_random_arbiter
  import lfsr_random_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input logic                  clock,
  input logic                  reset,
  lfsr_random_arbiter_if.slave bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            state;
  state_t            state_next;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  idx;
  logic [PTR_W-1:0]  pick;
  logic [N_REQ-1:0]  eligible;
  logic              found;
  logic              grant;
  logic              accept;
  logic              seed_load;
  logic              draw_en;
  logic [LFSR_W-1:0] lfsr_val;
  logic [LFSR_W-1:0] lim_pick;
  logic [LFSR_W-1:0] lim_q;
  logic [LFSR_W-1:0] mask;
  logic [LFSR_W-1:0] cand;

  assign draw_en = (state == DRAW);

  lfsr_core_7b u_lfsr (
    .clock    (clock),
    .reset    (reset),
    .enable   (draw_en),
    .load     (seed_load),
    .load_val (bus.seed),
    .out      (lfsr_val)
  );

  // A requester being acked this cycle is skipped so it is not served twice.
  always_comb begin
    int pos;
    pick     = '0;
    found    = 1'b0;
    pos      = 0;
    eligible = bus.req & ~bus.ack;
    for (int k = 0; k < N_REQ; k++) begin
      pos = (int'(ptr) + k) % N_REQ;
      if (!found && eligible[pos]) begin
        found = 1'b1;
        pick  = PTR_W'(pos);
      end
    end
  end

  assign lim_pick = bus.lim[LFSR_W*int'(pick) +: LFSR_W];
  assign mask     = lfsr_mask(lim_q);
  assign cand     = lfsr_val & mask;
  assign bus.busy = draw_en;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    accept     = 1'b0;
    seed_load  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.seed_ld) begin
          seed_load = 1'b1;
        end else if (found) begin
          grant      = 1'b1;
          state_next = DRAW;
        end
      end
      DRAW: begin
        if (cand < lim_q) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A zero bound is promoted to one so the draw always terminates with value 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr      <= '0;
      idx      <= '0;
      lim_q    <= '0;
      bus.ack  <= '0;
      bus.data <= '0;
    end else begin
      bus.ack <= '0;
      if (grant) begin
        idx   <= pick;
        lim_q <= (lim_pick == '0) ? LFSR_W'(1) : lim_pick;
      end
      if (accept) begin
        bus.data <= cand;
        bus.ack  <= N_REQ'(1) << idx;
        ptr      <= (idx == PTR_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_random_arbiter.sv
// Directed, table-driven bench for lfsr_random_arbiter with hand-computed
// LFSR draws plus multi-cycle corner sequences.
module tb_lfsr_random_arbiter;

  logic clock;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  lfsr_random_arbiter_if #(.N_REQ(4)) bus ();

  lfsr_random_arbiter #(.N_REQ(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       do_seed;
    logic [6:0] seed;
    int         req_idx;
    logic [6:0] lim;
    logic [6:0] exp_data;
    int         exp_draws;
    logic [6:0] exp_lfsr;
  } vec_t;

  vec_t vecs[12];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic reset_dut();
    reset       = 1'b0;
    bus.req     = '0;
    bus.seed_ld = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic load_seed(input logic [6:0] value);
    bus.seed    = value;
    bus.seed_ld = 1'b1;
    @(posedge clock);
    #1;
    bus.seed_ld = 1'b0;
  endtask

  // Raise one request, wait (bounded) for its ack, count DRAW cycles, then drop it.
  task automatic apply_stimulus(input int r, input logic [6:0] l, output int draws,
                                output logic [6:0] d, output logic [3:0] a);
    draws = 0;
    bus.lim[7*r +: 7] = l;
    bus.req[r] = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(posedge clock);
      #1;
      if (bus.busy) draws++;
      if (bus.ack != 4'b0000) break;
    end
    if (bus.ack == 4'b0000) begin
      failures++;
      $display("[TB] FAIL ack_timeout req=%0d actual=no_ack expected=ack", r);
    end
    a = bus.ack;
    d = bus.data;
    bus.req[r] = 1'b0;
  endtask

  initial begin
    int         draws;
    logic [6:0] d;
    logic [3:0] a;
    int         n;
    int         grant_seq[3];
    int         ack_cyc[3];

    vecs[0]  = '{1'b0, 7'h00, 0, 7'd5,   7'h04, 1, 7'h42};
    vecs[1]  = '{1'b0, 7'h00, 0, 7'd8,   7'h02, 1, 7'h21};
    vecs[2]  = '{1'b1, 7'h07, 1, 7'd3,   7'h01, 3, 7'h30};
    vecs[3]  = '{1'b1, 7'h7F, 2, 7'd0,   7'h00, 1, 7'h42};
    vecs[4]  = '{1'b0, 7'h00, 3, 7'd1,   7'h00, 1, 7'h21};
    vecs[5]  = '{1'b0, 7'h00, 2, 7'd100, 7'h21, 1, 7'h10};
    vecs[6]  = '{1'b0, 7'h00, 1, 7'd127, 7'h10, 1, 7'h48};
    vecs[7]  = '{1'b0, 7'h00, 0, 7'd64,  7'h08, 1, 7'h64};
    vecs[8]  = '{1'b0, 7'h00, 3, 7'd65,  7'h39, 3, 7'h1C};
    vecs[9]  = '{1'b1, 7'h55, 1, 7'd2,   7'h01, 1, 7'h2A};
    vecs[10] = '{1'b0, 7'h00, 2, 7'd6,   7'h02, 1, 7'h15};
    vecs[11] = '{1'b0, 7'h00, 0, 7'd5,   7'h02, 2, 7'h05};

    reset       = 1'b0;
    bus.req     = '0;
    bus.lim     = '0;
    bus.seed    = '0;
    bus.seed_ld = 1'b0;
    @(posedge clock);
    #1;
    check_output("reset_ack", bus.ack, 4'b0000);
    check_output("reset_data", bus.data, 7'h00);
    check_output("reset_busy", bus.busy, 1'b0);
    check_output("reset_lfsr", dut.u_lfsr.out, 7'h04);
    check_output("reset_ptr", dut.ptr, 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      logic [3:0] exp_ack;
      exp_ack = 4'b0001 << vecs[i].req_idx;
      if (vecs[i].do_seed) load_seed(vecs[i].seed);
      apply_stimulus(vecs[i].req_idx, vecs[i].lim, draws, d, a);
      check_output($sformatf("vec%0d_ack", i), a, exp_ack);
      check_output($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      check_output($sformatf("vec%0d_draws", i), draws, vecs[i].exp_draws);
      check_output($sformatf("vec%0d_lfsr", i), dut.u_lfsr.out, vecs[i].exp_lfsr);
    end

    // Round-robin with back-to-back service.
    reset_dut();
    bus.lim = {4{7'd1}};
    bus.req = 4'b1011;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      grant_seq[k] = -1;
      ack_cyc[k]   = -1;
    end
    for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
      @(posedge clock);
      #1;
      if (bus.ack != 4'b0000) begin
        for (int j = 0; j < 4; j++) if (bus.ack == (4'b0001 << j)) grant_seq[n] = j;
        ack_cyc[n] = cyc;
        n++;
        bus.req = bus.req & ~bus.ack;
      end
    end
    check_output("rr_count", n, 3);
    check_output("rr_first", grant_seq[0], 0);
    check_output("rr_second", grant_seq[1], 1);
    check_output("rr_third", grant_seq[2], 3);
    check_output("rr_gap01", ack_cyc[1] - ack_cyc[0], 2);
    check_output("rr_gap12", ack_cyc[2] - ack_cyc[1], 2);
    check_output("rr_ptr", dut.ptr, 0);
    bus.req = '0;

    // Seed strobe during DRAW must not disturb the draw sequence.
    reset_dut();
    load_seed(7'h07);
    bus.lim[13:7] = 7'd3;
    bus.req[1] = 1'b1;
    @(posedge clock);
    #1;
    check_output("sdraw_busy1", bus.busy, 1'b1);
    bus.seed    = 7'h55;
    bus.seed_ld = 1'b1;
    @(posedge clock);
    #1;
    bus.seed_ld = 1'b0;
    check_output("sdraw_busy2", bus.busy, 1'b1);
    check_output("sdraw_ack2", bus.ack, 4'b0000);
    @(posedge clock);
    #1;
    check_output("sdraw_busy3", bus.busy, 1'b1);
    check_output("sdraw_ack3", bus.ack, 4'b0000);
    @(posedge clock);
    #1;
    check_output("sdraw_ack", bus.ack, 4'b0010);
    check_output("sdraw_data", bus.data, 7'h01);
    check_output("sdraw_lfsr", dut.u_lfsr.out, 7'h30);
    bus.req = '0;

    // Seed strobe in IDLE wins over a pending request for that cycle.
    reset_dut();
    bus.seed      = 7'h55;
    bus.seed_ld   = 1'b1;
    bus.lim[6:0]  = 7'd5;
    bus.req[0]    = 1'b1;
    @(posedge clock);
    #1;
    bus.seed_ld = 1'b0;
    check_output("sidle_nogrant", bus.busy, 1'b0);
    check_output("sidle_lfsr", dut.u_lfsr.out, 7'h55);
    apply_stimulus(0, 7'd5, draws, d, a);
    check_output("sidle_data", d, 7'h02);
    check_output("sidle_draws", draws, 2);

    // Request held through its ack cycle: one-cycle ack, no second grant.
    reset_dut();
    bus.lim[6:0] = 7'd5;
    bus.req[0]   = 1'b1;
    @(posedge clock);
    #1;
    check_output("hold_busy", bus.busy, 1'b1);
    @(posedge clock);
    #1;
    check_output("hold_ack", bus.ack, 4'b0001);
    check_output("hold_data", bus.data, 7'h04);
    @(posedge clock);
    #1;
    check_output("hold_ack_drop", bus.ack, 4'b0000);
    check_output("hold_no_regrant", bus.busy, 1'b0);
    check_output("hold_data_kept", bus.data, 7'h04);
    bus.req[0] = 1'b0;

    // Asynchronous reset in the middle of a rejected draw drops the grant.
    load_seed(7'h07);
    bus.lim[13:7] = 7'd3;
    bus.req[1] = 1'b1;
    @(posedge clock);
    #1;
    check_output("mid_busy", bus.busy, 1'b1);
    @(posedge clock);
    #1;
    check_output("mid_lfsr_pre", dut.u_lfsr.out, 7'h43);
    reset   = 1'b0;
    bus.req = '0;
    #1;
    check_output("mid_ack", bus.ack, 4'b0000);
    check_output("mid_data", bus.data, 7'h00);
    check_output("mid_busy_low", bus.busy, 1'b0);
    check_output("mid_lfsr", dut.u_lfsr.out, 7'h04);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_output("mid_no_ack", bus.ack, 4'b0000);
    apply_stimulus(0, 7'd5, draws, d, a);
    check_output("mid_fresh_ack", a, 4'b0001);
    check_output("mid_fresh_data", d, 7'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
